// File: rtl/exception_ctrl_pkg.sv
// exception_ctrl_pkg: exception codes, CP0 register addresses, redirect vector and FSM states
package exception_ctrl_pkg;
  localparam logic [31:0] EXC_INT    = 32'h1;
  localparam logic [31:0] EXC_ADEL   = 32'h4;
  localparam logic [31:0] EXC_ADES   = 32'h5;
  localparam logic [31:0] EXC_SYS    = 32'h8;
  localparam logic [31:0] EXC_BP     = 32'h9;
  localparam logic [31:0] EXC_RI     = 32'ha;
  localparam logic [31:0] EXC_OV     = 32'hc;
  localparam logic [31:0] EXC_TR     = 32'hd;
  localparam logic [31:0] EXC_ERET   = 32'he;
  localparam logic [4:0]  CP0_STATUS = 5'd12;
  localparam logic [4:0]  CP0_CAUSE  = 5'd13;
  localparam logic [4:0]  CP0_EPC    = 5'd14;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;
  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;
endpackage

// File: rtl/exception_ctrl_int_sync.sv
// int_sync: 6-bit two-flop synchroniser for external interrupt lines
// ports: clk, rst (sync, active-high), i_async raw lines, o_sync synchronised lines
module int_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_async,
  output logic [5:0] o_sync
);
  logic [5:0] r_meta, r_sync;
  always_ff @(posedge clk) begin
    r_meta <= rst ? 6'h0 : i_async;
    r_sync <= rst ? 6'h0 : r_meta;
  end
  assign o_sync = r_sync;
endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: MEM-stage exception arbiter issuing a one-cycle registered commit to CP0 and fetch
// ports: MEM instruction + exception flags, hw_int_i, CP0 values with WB mtc0 forwarding in;
//        int_sync_o, combinational mem_kill_o, registered payload pulse (excepttype/epc source/badvaddr/flush/new_pc) out
module exception_ctrl
  import exception_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] data_addr_i,
  input  logic        if_adel_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        trap_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        eret_i,
  input  logic        ld_adel_i,
  input  logic        st_ades_i,
  input  logic [5:0]  hw_int_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [5:0]  int_sync_o,
  output logic        mem_kill_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);
  state_t      r_state;
  logic [31:0] r_excepttype, r_pc, r_bad, r_new_pc;
  logic        r_ds, r_flush;
  logic [31:0] w_status, w_epc, w_code, w_bad;
  logic [7:0]  w_ip;
  logic [1:0]  w_swi;
  logic        w_int, w_hit, w_commit, w_unused;
  int_sync u_int_sync (.clk(clk), .rst(rst), .i_async(hw_int_i), .o_sync(int_sync_o));
  assign w_status = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_STATUS) ? wb_cp0_data_i : cp0_status_i;
  assign w_swi    = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_CAUSE) ? wb_cp0_data_i[9:8] : cp0_cause_i[9:8];
  assign w_epc    = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EPC) ? wb_cp0_data_i : cp0_epc_i;
  assign w_ip     = {int_sync_o, w_swi};
  assign w_int    = w_status[0] & ~w_status[1] & |(w_ip & w_status[15:8]);
  assign w_code   = w_int ? EXC_INT : if_adel_i ? EXC_ADEL : ri_i ? EXC_RI : ov_i ? EXC_OV :
                    trap_i ? EXC_TR : syscall_i ? EXC_SYS : break_i ? EXC_BP : eret_i ? EXC_ERET :
                    ld_adel_i ? EXC_ADEL : st_ades_i ? EXC_ADES : 32'h0;
  // an instruction-fetch ADEL reports the PC; data-side ADEL/ADES report the data address
  assign w_bad    = (w_code == EXC_INT) ? 32'h0 : if_adel_i ? mem_pc_i :
                    (w_code == EXC_ADEL || w_code == EXC_ADES) ? data_addr_i : 32'h0;
  assign w_hit    = ~rst & mem_valid_i & (r_state == ST_IDLE) & (|w_code);
  assign w_commit = w_hit & ~stall_i;
  assign mem_kill_o = w_hit;
  assign w_unused = &{1'b0, cp0_cause_i[31:10], cp0_cause_i[7:0], w_status[31:16], w_status[7:2]};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_excepttype <= 32'h0;
      r_pc         <= 32'h0;
      r_ds         <= 1'b0;
      r_bad        <= 32'h0;
      r_flush      <= 1'b0;
      r_new_pc     <= 32'h0;
    end else begin
      r_state      <= w_commit ? ST_FLUSH : ST_IDLE;
      r_excepttype <= w_commit ? w_code : 32'h0;
      r_pc         <= w_commit ? mem_pc_i : 32'h0;
      r_ds         <= w_commit & mem_in_delayslot_i;
      r_bad        <= w_commit ? w_bad : 32'h0;
      r_flush      <= w_commit;
      r_new_pc     <= !w_commit ? 32'h0 : (w_code == EXC_ERET) ? w_epc : EXC_VECTOR;
    end
  end
  assign excepttype_o        = r_excepttype;
  assign current_inst_addr_o = r_pc;
  assign is_in_delayslot_o   = r_ds;
  assign bad_addr_o          = r_bad;
  assign flush_o             = r_flush;
  assign new_pc_o            = r_new_pc;
endmodule
